encoder_scan_scheduler: RTL and testbench

Time-multiplexed quadrature-encoder controller for the three-channel RGB mixer. One shared transition decoder and one shared up/down adder serve encoders 0..2 in strict round-robin slots. The block maintains one WIDTH-bit level register per channel; these levels feed the three PWM duty inputs. A host load port lets firmware or test logic preset any channel level.

---
 rtl/encoder_scan_scheduler.sv | 116 +++++++++++
 tb/tb_encoder_scan_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/encoder_scan_scheduler.sv
// Round-robin quadrature decoder with three level registers; ENC_SAT_EN selects saturating levels (else wrap).
// Pin-to-level latency is 2 sync + up to 3*SCAN_DIV-1 slot wait + 1 cycle; loads complete in one cycle once load_ready rises.
module encoder_scan_scheduler #(
    parameter int WIDTH    = 8,
    parameter int SCAN_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       enc_a,
    input  logic [2:0]       enc_b,
    input  logic             load_valid,
    input  logic [1:0]       load_ch,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic [WIDTH-1:0] level0,
    output logic [WIDTH-1:0] level1,
    output logic [WIDTH-1:0] level2,
    output logic [2:0]       step_pulse
);

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

    logic [2:0]                  a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic [7:0]                  div_q, div_d;
    logic [1:0]                  slot_q, slot_d;
    logic [2:0]                  seen_q, seen_d;
    logic [2:0][1:0]             prev_q, prev_d;
    logic [2:0][WIDTH-1:0]       lvl_q, lvl_d;
    logic [2:0]                  pulse_q, pulse_d;
    logic [1:0]                  rdy_q;

    logic             tick;
    logic [1:0]       cur_ab, prev_ab, diff;
    logic             fwd, rev, clamp, count, load_hit;
    logic [WIDTH-1:0] cur_lvl, step_val, add_res;

    // Gray sequence 00,01,11,10 mapped to 0..3 so direction is a modulo-4 difference.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    always_comb begin
        tick     = (div_q == DIV_LAST);
        cur_ab   = {a_s2_q[slot_q], b_s2_q[slot_q]};
        prev_ab  = prev_q[slot_q];
        diff     = gray_idx(cur_ab) - gray_idx(prev_ab);
        fwd      = (diff == 2'd1);
        rev      = (diff == 2'd3);
        cur_lvl  = lvl_q[slot_q];
        step_val = fwd ? WIDTH'(1) : {WIDTH{1'b1}};
        add_res  = cur_lvl + step_val;
`ifdef ENC_SAT_EN
        clamp    = (fwd && (cur_lvl == {WIDTH{1'b1}})) || (rev && (cur_lvl == '0));
`else
        clamp    = 1'b0;
`endif
        count    = tick && seen_q[slot_q] && (fwd || rev) && !clamp;
        load_hit = load_valid && rdy_q[1] && (load_ch != 2'd3);

        div_d   = tick ? 8'd0 : div_q + 8'd1;
        slot_d  = slot_q;
        seen_d  = seen_q;
        prev_d  = prev_q;
        lvl_d   = lvl_q;
        pulse_d = '0;

        if (tick) begin
            slot_d         = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
            seen_d[slot_q] = 1'b1;
            prev_d[slot_q] = cur_ab;
        end
        // A host load to the channel being serviced overrides the encoder step.
        if (count && !(load_hit && (load_ch == slot_q))) begin
            lvl_d[slot_q]   = add_res;
            pulse_d[slot_q] = 1'b1;
        end
        if (load_hit) begin
            lvl_d[load_ch] = load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_s1_q  <= '0;
            a_s2_q  <= '0;
            b_s1_q  <= '0;
            b_s2_q  <= '0;
            div_q   <= '0;
            slot_q  <= '0;
            seen_q  <= '0;
            prev_q  <= '0;
            lvl_q   <= '0;
            pulse_q <= '0;
            rdy_q   <= '0;
        end else begin
            a_s1_q  <= enc_a;
            a_s2_q  <= a_s1_q;
            b_s1_q  <= enc_b;
            b_s2_q  <= b_s1_q;
            div_q   <= div_d;
            slot_q  <= slot_d;
            seen_q  <= seen_d;
            prev_q  <= prev_d;
            lvl_q   <= lvl_d;
            pulse_q <= pulse_d;
            rdy_q   <= {rdy_q[0], 1'b1};
        end
    end

    assign load_ready = rdy_q[1];
    assign level0     = lvl_q[0];
    assign level1     = lvl_q[1];
    assign level2     = lvl_q[2];
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_encoder_scan_scheduler.sv
// Directed bench for encoder_scan_scheduler (WIDTH=8, SCAN_DIV=4); expectations follow ENC_SAT_EN.
module tb_encoder_scan_scheduler;
    localparam int W = 8;

`ifdef ENC_SAT_EN
    localparam int REV_LVL = 0,   REV_P = 0, WRAP_LVL = 255, WRAP_P = 0;
`else
    localparam int REV_LVL = 253, REV_P = 3, WRAP_LVL = 0,   WRAP_P = 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   enc_a = 3'b111;
    logic [2:0]   enc_b = 3'b111;
    logic         load_valid = 1'b0;
    logic [1:0]   load_ch = 2'd0;
    logic [W-1:0] load_data = '0;
    logic         load_ready;
    logic [W-1:0] level0, level1, level2;
    logic [2:0]   step_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pc0 = 0, pc1 = 0, pc2 = 0;
    int p;
    logic [1:0] fseq [4];
    logic [1:0] rseq [3];

    encoder_scan_scheduler #(.WIDTH(W), .SCAN_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .load_valid (load_valid),
        .load_ch    (load_ch),
        .load_data  (load_data),
        .load_ready (load_ready),
        .level0     (level0),
        .level1     (level1),
        .level2     (level2),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc = 0;
        else       cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (step_pulse[0]) pc0 = pc0 + 1;
        if (step_pulse[1]) pc1 = pc1 + 1;
        if (step_pulse[2]) pc2 = pc2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ab(input int ch, input logic [1:0] ab);
        enc_a[ch] = ab[1];
        enc_b[ch] = ab[0];
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stops at the negedge just before DUT edge number k with k % 12 == r.
    task automatic wait_mod(input int r);
        @(negedge clk);
        for (int i = 0; i < 12 && ((cyc + 1) % 12 != r); i++) @(negedge clk);
    endtask

    task automatic do_load(input logic [1:0] ch, input logic [W-1:0] d);
        load_valid = 1'b1;
        load_ch    = ch;
        load_data  = d;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    initial begin
        fseq[0] = 2'b01; fseq[1] = 2'b11; fseq[2] = 2'b10; fseq[3] = 2'b00;
        rseq[0] = 2'b01; rseq[1] = 2'b00; rseq[2] = 2'b10;

        wait_cyc(3);
        chk("rst_level0", level0, 0);
        chk("rst_level1", level1, 0);
        chk("rst_level2", level2, 0);
        chk("rst_pulse", step_pulse, 0);
        chk("rst_ready", load_ready, 0);

        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_edge1", load_ready, 0);
        @(posedge clk); #1;
        chk("ready_edge2", load_ready, 1);

        wait_cyc(100);
        chk("idle_level0", level0, 0);
        chk("idle_level1", level1, 0);
        chk("idle_level2", level2, 0);
        chk("idle_pulses", pc0 + pc1 + pc2, 0);

        // 11 -> 00 is a double change (dropped), then four forward steps.
        set_ab(0, 2'b00);
        wait_cyc(16);
        for (int i = 0; i < 4; i++) begin
            set_ab(0, fseq[i]);
            wait_cyc(16);
        end
        chk("fwd_level0", level0, 4);
        chk("fwd_pulses0", pc0, 4);
        chk("fwd_level1", level1, 0);
        chk("fwd_level2", level2, 0);

        p = pc2;
        for (int i = 0; i < 3; i++) begin
            set_ab(2, rseq[i]);
            wait_cyc(16);
        end
        chk("rev_level2", level2, REV_LVL);
        chk("rev_pulses2", pc2 - p, REV_P);

        wait_cyc(1);
        do_load(2'd3, 8'h55);
        chk("noop_level0", level0, 4);
        chk("noop_level1", level1, 0);
        chk("noop_level2", level2, REV_LVL);

        // Forward step 11->10 on ch1 reaches its slot on the same edge as the load.
        wait_mod(8);
        @(posedge clk);
        @(negedge clk);
        set_ab(1, 2'b10);
        p = pc1;
        wait_mod(8);
        do_load(2'd1, 8'h80);
        chk("coll_level1", level1, 8'h80);
        chk("coll_pulse1", step_pulse[1], 0);
        wait_cyc(16);
        chk("coll_hold1", level1, 8'h80);
        chk("coll_pulses1", pc1 - p, 0);

        set_ab(1, 2'b00);
        wait_cyc(16);
        chk("ch1_fwd", level1, 8'h81);
        set_ab(1, 2'b11);
        wait_cyc(16);
        chk("ch1_double", level1, 8'h81);
        set_ab(1, 2'b01);
        wait_cyc(16);
        chk("ch1_rev", level1, 8'h80);

        p = pc2;
        wait_cyc(1);
        do_load(2'd2, 8'hFF);
        chk("load_ff", level2, 8'hFF);
        set_ab(2, 2'b00);
        wait_cyc(16);
        chk("wrap_level2", level2, WRAP_LVL);
        chk("wrap_pulses2", pc2 - p, WRAP_P);

        set_ab(0, 2'b01);
        wait_cyc(16);
        chk("pre_rst_level0", level0, 5);

        set_ab(0, 2'b11);
        wait_cyc(5);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_level0", level0, 0);
        chk("mid_rst_level1", level1, 0);
        chk("mid_rst_level2", level2, 0);
        chk("mid_rst_ready", load_ready, 0);
        chk("mid_rst_pulse", step_pulse, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_cyc(16);
        chk("post_rst_init", level0, 0);
        p = pc0;
        set_ab(0, 2'b10);
        wait_cyc(16);
        chk("post_rst_step", level0, 1);
        chk("post_rst_pulse", pc0 - p, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
